// File: rtl/addsub_seq.sv
// Sequential adder/subtractor: processes CHUNK bits per cycle, LSB slice first.
// Define ADDSUB_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module addsub_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef ADDSUB_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("addsub_seq: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              cy_q;
    logic [WIDTH-1:0]  a_q, b_q, res_q;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_q;
    logic              in_ready_q, out_valid_q;

    logic [31:0]       base;
    logic [CHUNK-1:0]  a_sl, b_sl;
    logic [CHUNK:0]    slice;
    logic [WIDTH-1:0]  res_d;
    logic              last;

    always_comb begin
        base  = 32'(cnt_q) * CHUNK;
        a_sl  = a_q[base +: CHUNK];
        b_sl  = b_q[base +: CHUNK];
        slice = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, cy_q};
        res_d = res_q;
        res_d[base +: CHUNK] = slice[CHUNK-1:0];
        last  = (cnt_q == CntW'(N - 1));
    end

`ifdef ADDSUB_SEQ_OVF_EN
    logic ovf_q;
    logic msb_cin;
    // Carry into the MSB recovered from the MSB sum bit and its two addend bits.
    assign msb_cin = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice[CHUNK-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == StRun && last) begin
            ovf_q <= msb_cin ^ slice[CHUNK];
        end
    end

    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cy_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        // Subtraction as a + ~b + 1: invert b here, carry-in supplies the +1.
                        a_q        <= a;
                        b_q        <= b ^ {WIDTH{sub}};
                        cy_q       <= sub;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    cy_q  <= slice[CHUNK];
                    res_q <= res_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        sum_q       <= res_d;
                        carry_q     <= slice[CHUNK];
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq: a 32/8 instance and a 16/16 instance share clock and reset.
module tb_addsub_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, sub, out_valid, out_ready, carry;
    logic [31:0] a, b, sum;
    logic        in_valid16, in_ready16, sub16, out_valid16, out_ready16, carry16;
    logic [15:0] a16, b16, sum16;
`ifdef ADDSUB_SEQ_OVF_EN
    logic        ovf, ovf16;
`endif

    addsub_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry)
`ifdef ADDSUB_SEQ_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    addsub_seq #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .sub       (sub16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .sum       (sum16),
        .carry     (carry16)
`ifdef ADDSUB_SEQ_OVF_EN
        ,
        .ovf       (ovf16)
`endif
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                   input logic sv, input int w);
        exp_t        e;
        logic [31:0] mask, bb, am;
        logic [32:0] full;
        mask    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        am      = av & mask;
        bb      = (bv ^ {32{sv}}) & mask;
        full    = {1'b0, am} + {1'b0, bb} + 33'(sv);
        e.sum   = full[31:0] & mask;
        e.carry = full[w];
        e.ovf   = (am[w-1] == bb[w-1]) && (e.sum[w-1] != am[w-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept32(input logic [31:0] av, input logic [31:0] bv, input logic sv);
        int w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a = av; b = bv; sub = sv; in_valid = 1'b1;
        sb.push_back(model(av, bv, sv, 32));
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom);
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
    endtask

    task automatic complete32(input int hold);
        int   lat = 0;
        exp_t e;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            a = $urandom; b = $urandom; sub = 1'($urandom); in_valid = 1'($urandom);
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), 32'd4);
        e = sb.pop_front();
        check("sum", sum, e.sum);
        check("carry", 32'(carry), 32'(e.carry));
`ifdef ADDSUB_SEQ_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
        for (int i = 0; i < hold; i++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom); in_valid = 1'($urandom);
            @(negedge clk);
            check("hold_sum", sum, e.sum);
            check("hold_carry", 32'(carry), 32'(e.carry));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_done", 32'(in_ready), 32'd1);
        check("out_valid_after_done", 32'(out_valid), 32'd0);
        check("sum_retained_idle", sum, e.sum);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   lat;
        int   seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", sum, 32'd0);
        check("reset_carry", 32'(carry), 32'd0);
        check("reset_in_ready16", 32'(in_ready16), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_in_ready16", 32'(in_ready16), 32'd1);

        accept32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0); complete32(0);
        accept32(32'd5, 32'd7, 1'b1);                 complete32(0);
        accept32(32'd7, 32'd5, 1'b1);                 complete32(10);
        accept32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0); complete32(0);
        accept32(32'h8000_0000, 32'h0000_0001, 1'b1); complete32(0);
        for (int i = 0; i < 4; i++) begin
            accept32($urandom, $urandom, 1'($urandom));
            complete32(i);
        end
        accept32(32'hDEAD_BEEF, 32'h1234_5678, 1'b0); complete32(0);

        // Reset in the second RUN cycle aborts the operation.
        accept32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", sum, 32'd0);
        check("abort_carry", 32'(carry), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
`ifdef ADDSUB_SEQ_OVF_EN
        check("abort_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        check("abort_no_out_valid", 32'(seen), 32'd0);
        check("abort_in_ready_release", 32'(in_ready), 32'd1);
        accept32(32'h0000_00FF, 32'h0000_0001, 1'b0); complete32(0);

        // Single-slice instance: WIDTH == CHUNK.
        a16 = 16'h8000; b16 = 16'h8000; sub16 = 1'b0; in_valid16 = 1'b1;
        sb.push_back(model(32'h8000, 32'h8000, 1'b0, 16));
        @(negedge clk);
        in_valid16 = 1'b0; a16 = 16'h1234; b16 = 16'h4321; sub16 = 1'b1;
        lat = 0;
        while (out_valid16 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("w16_latency", 32'(lat), 32'd1);
        e = sb.pop_front();
        check("w16_sum", 32'(sum16), e.sum);
        check("w16_carry", 32'(carry16), 32'(e.carry));
`ifdef ADDSUB_SEQ_OVF_EN
        check("w16_ovf", 32'(ovf16), 32'(e.ovf));
`endif
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        check("w16_in_ready", 32'(in_ready16), 32'd1);

        a16 = 16'h0003; b16 = 16'h0005; sub16 = 1'b1; in_valid16 = 1'b1;
        sb.push_back(model(32'h0003, 32'h0005, 1'b1, 16));
        @(negedge clk);
        in_valid16 = 1'b0;
        lat = 0;
        while (out_valid16 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("w16_sub_latency", 32'(lat), 32'd1);
        e = sb.pop_front();
        check("w16_sub_sum", 32'(sum16), e.sum);
        check("w16_sub_carry", 32'(carry16), 32'(e.carry));
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
